// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_pkg
// Shared encodings for the decode/execute hazard controller: FSM states,
// forwarding selects and the packed scoreboard slot layout.
// Revision: 1.0
// ============================================================================
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Slot layout, LSB first: flags, then rd, rs1, rs2 (each RA_W wide).
  localparam int SLOT_VALID = 0;
  localparam int SLOT_RW    = 1;
  localparam int SLOT_LOAD  = 2;
  localparam int SLOT_USE1  = 3;
  localparam int SLOT_USE2  = 4;
  localparam int SLOT_FLAGS = 5;

  localparam int CNT_W = 3;

  function automatic int slot_width(input int ra_w);
    return SLOT_FLAGS + 3 * ra_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard
// Three-slot EX/MEM/WB shift register with destination match logic against
// the decode sources and against the EX slot's own sources.
// Revision: 1.0
// ============================================================================
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_load_en,
  input  logic [RA_W-1:0] dec_rs1,
  input  logic [RA_W-1:0] dec_rs2,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic [RA_W-1:0] dec_rd,
  input  logic            dec_rw,
  input  logic            dec_load,
  output logic [2:0]      slot_load,
  output logic [2:0]      dec_hit,
  output logic [2:1]      ex_rs1_hit,
  output logic [2:1]      ex_rs2_hit
);

  localparam int SW     = slot_width(RA_W);
  localparam int RD_LO  = SLOT_FLAGS;
  localparam int RS1_LO = RD_LO + RA_W;
  localparam int RS2_LO = RS1_LO + RA_W;

  logic [SW-1:0]   dec_slot;
  logic [SW-1:0]   slot_q [3];
  logic [2:0]      slot_src;
  logic [RA_W-1:0] slot_rd [3];
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic            ex_use1;
  logic            ex_use2;

  assign dec_slot = {dec_rs2, dec_rs1, dec_rd, dec_use_rs2, dec_use_rs1,
                     dec_load, dec_rw, 1'b1};

  // Back end never stalls: MEM and WB always shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      slot_q[2] <= '0;
    end else begin
      slot_q[0] <= ex_load_en ? dec_slot : '0;
      slot_q[1] <= slot_q[0];
      slot_q[2] <= slot_q[1];
    end
  end

  for (genvar s = 0; s < 3; s++) begin : g_slot
    assign slot_rd[s]   = slot_q[s][RD_LO +: RA_W];
    assign slot_src[s]  = slot_q[s][SLOT_VALID] && slot_q[s][SLOT_RW] &&
                          (slot_rd[s] != '0);
    assign slot_load[s] = slot_q[s][SLOT_LOAD];
    assign dec_hit[s]   = slot_src[s] &&
                          ((dec_use_rs1 && (dec_rs1 == slot_rd[s])) ||
                           (dec_use_rs2 && (dec_rs2 == slot_rd[s])));
  end

  assign ex_rs1  = slot_q[0][RS1_LO +: RA_W];
  assign ex_rs2  = slot_q[0][RS2_LO +: RA_W];
  assign ex_use1 = slot_q[0][SLOT_VALID] && slot_q[0][SLOT_USE1];
  assign ex_use2 = slot_q[0][SLOT_VALID] && slot_q[0][SLOT_USE2];

  for (genvar m = 1; m < 3; m++) begin : g_fwd_match
    assign ex_rs1_hit[m] = ex_use1 && slot_src[m] && (slot_rd[m] == ex_rs1);
    assign ex_rs2_hit[m] = ex_use2 && slot_src[m] && (slot_rd[m] == ex_rs2);
  end

  // Source fields of MEM/WB are carried for visibility but never compared.
  logic unused_fields;
  assign unused_fields = ^{slot_q[1][SW-1:RS1_LO], slot_q[1][SLOT_USE2:SLOT_USE1],
                           slot_q[2][SW-1:RS1_LO], slot_q[2][SLOT_USE2:SLOT_USE1]};

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl
// Stall/flush/forward control for the decode-to-execute pipeline register.
// Define HAZARD_FWD_EN to enable operand forwarding; otherwise RAW hazards
// stall decode until the producer has retired.
// Revision: 1.0
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic [RA_W-1:0] dec_rs1,
  input  logic [RA_W-1:0] dec_rs2,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic [RA_W-1:0] dec_rd,
  input  logic            dec_rw,
  input  logic            dec_load,
  input  logic            ex_redirect,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             stall;
  logic             flush;
  logic             data_hazard;
  logic             ex_load_en;
  logic [2:0]       slot_load;
  logic [2:0]       dec_hit;
  logic [2:1]       ex_rs1_hit;
  logic [2:1]       ex_rs2_hit;

  assign ex_load_en = dec_valid && !stall_ifid && !flush_idex;

  hazard_scoreboard #(
    .RA_W (RA_W)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .ex_load_en  (ex_load_en),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_use_rs1 (dec_use_rs1),
    .dec_use_rs2 (dec_use_rs2),
    .dec_rd      (dec_rd),
    .dec_rw      (dec_rw),
    .dec_load    (dec_load),
    .slot_load   (slot_load),
    .dec_hit     (dec_hit),
    .ex_rs1_hit  (ex_rs1_hit),
    .ex_rs2_hit  (ex_rs2_hit)
  );

`ifdef HAZARD_FWD_EN
  assign data_hazard = dec_valid && slot_load[0] && dec_hit[0];
`else
  assign data_hazard = dec_valid && (|dec_hit);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    flush    = 1'b0;
    case (state)
      ST_RUN: begin
        stall = data_hazard;
`ifdef HAZARD_FWD_EN
        if (data_hazard) state_nx = ST_LSTALL;
`endif
      end
      ST_LSTALL: begin
        stall    = data_hazard;
        state_nx = ST_RUN;
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cnt > CNT_ONE) begin
          cnt_nx = cnt - CNT_ONE;
        end else begin
          cnt_nx   = '0;
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
    // A taken redirect squashes whatever decode holds, so stalling is moot.
    if (ex_redirect) begin
      stall = 1'b0;
      flush = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_nx = ST_FLUSH;
        cnt_nx   = FLUSH_LOAD;
      end else begin
        state_nx = ST_RUN;
        cnt_nx   = '0;
      end
    end
    if (reset) begin
      stall = 1'b0;
      flush = 1'b0;
    end
  end

  assign stall_pc   = stall;
  assign stall_ifid = stall;
  assign flush_ifid = flush;
  assign flush_idex = flush || stall;

`ifdef HAZARD_FWD_EN
  // A load still in MEM has no data yet; the load-use stall moves it to WB.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!reset) begin
      if (ex_rs1_hit[1] && !slot_load[1]) fwd_a = FWD_MEM;
      else if (ex_rs1_hit[2])             fwd_a = FWD_WB;
      if (ex_rs2_hit[1] && !slot_load[1]) fwd_b = FWD_MEM;
      else if (ex_rs2_hit[2])             fwd_b = FWD_WB;
    end
  end

  logic unused_sb;
  assign unused_sb = ^{slot_load[2], dec_hit[2:1]};
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  logic unused_sb;
  assign unused_sb = ^{slot_load, ex_rs1_hit, ex_rs2_hit};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl; expectations follow HAZARD_FWD_EN.
// Revision: 1.0
// ============================================================================
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_use_rs1;
  logic       dec_use_rs2;
  logic [4:0] dec_rd;
  logic       dec_rw;
  logic       dec_load;
  logic       ex_redirect;
  logic       stall_pc;
  logic       stall_ifid;
  logic       flush_ifid;
  logic       flush_idex;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  int n_tests = 0;
  int n_fail  = 0;

  // {stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b}
  localparam logic [7:0] E0     = 8'b0000_0000;
  localparam logic [7:0] ESTALL = 8'b1101_0000;
  localparam logic [7:0] EFLUSH = 8'b0011_0000;

  hazard_ctrl #(
    .RA_W         (5),
    .FLUSH_CYCLES (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_use_rs1 (dec_use_rs1),
    .dec_use_rs2 (dec_use_rs2),
    .dec_rd      (dec_rd),
    .dec_rw      (dec_rw),
    .dec_load    (dec_load),
    .ex_redirect (ex_redirect),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (stall_pc,stall_ifid,flush_ifid,flush_idex,fwd_a,fwd_b)",
               tag, got, exp);
    end
  endtask

  task automatic ins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic ld);
    dec_valid   = 1'b1;
    dec_rd      = rd;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    dec_use_rs1 = u1;
    dec_use_rs2 = u2;
    dec_rw      = 1'b1;
    dec_load    = ld;
  endtask

  task automatic nop();
    dec_valid   = 1'b0;
    dec_rd      = '0;
    dec_rs1     = '0;
    dec_rs2     = '0;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_rw      = 1'b0;
    dec_load    = 1'b0;
  endtask

  // Inputs are applied just after a falling edge; outputs are checked 1 ns later.
  task automatic cyc(input string tag, input logic [7:0] exp);
    #1;
    check_val(tag, {stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b}, exp);
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    ex_redirect = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    ex_redirect = 1'b0;
    nop();
    repeat (2) @(negedge clk);

    // Outputs held at zero while reset is high, even with hazards present
    ins(5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    cyc("reset_outputs", E0);
    reset = 1'b0; ex_redirect = 1'b0; nop();
    cyc("idle_after_reset", E0);
    drain();

`ifdef HAZARD_FWD_EN
    // Back-to-back ALU dependency: MEM forward
    ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);  cyc("alu_prod", E0);
    ins(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);  cyc("alu_dep_nostall", E0);
    nop();                                     cyc("alu_fwd_mem", 8'b0000_0100);
    drain();
    // One intervening instruction: WB for rs1, MEM for rs2
    ins(5'd9,  5'd3,  5'd4,  1'b1, 1'b1, 1'b0); cyc("gap_prod", E0);
    ins(5'd10, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0); cyc("gap_mid", E0);
    ins(5'd11, 5'd9,  5'd10, 1'b1, 1'b1, 1'b0); cyc("gap_dep", E0);
    nop();                                      cyc("gap_fwd_wb_mem", 8'b0000_1001);
    drain();
    // Load-use: one stall cycle, then WB forward on both operands
    ins(5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);  cyc("lu_load", E0);
    ins(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);  cyc("lu_stall", ESTALL);
                                               cyc("lu_lstall_release", E0);
    nop();                                     cyc("lu_fwd_wb", 8'b0000_1010);
                                               cyc("lu_no_more_stall", E0);
    drain();
    // Same rd in MEM and WB: MEM wins
    ins(5'd14, 5'd1,  5'd2,  1'b1, 1'b1, 1'b0); cyc("prio_old", E0);
    ins(5'd14, 5'd3,  5'd4,  1'b1, 1'b1, 1'b0); cyc("prio_new", E0);
    ins(5'd21, 5'd14, 5'd14, 1'b1, 1'b1, 1'b0); cyc("prio_dep", E0);
    nop();                                      cyc("prio_mem_over_wb", 8'b0000_0101);
    drain();
`else
    // Without forwarding a RAW dependency stalls until the producer retires
    ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);  cyc("alu_prod", E0);
    ins(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0);  cyc("alu_stall_ex", ESTALL);
                                               cyc("alu_stall_mem", ESTALL);
                                               cyc("alu_stall_wb", ESTALL);
                                               cyc("alu_issue", E0);
    nop();                                     cyc("alu_fwd_tied", E0);
    drain();
    ins(5'd9,  5'd3,  5'd4,  1'b1, 1'b1, 1'b0); cyc("gap_prod", E0);
    ins(5'd10, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0); cyc("gap_mid", E0);
    ins(5'd11, 5'd9,  5'd10, 1'b1, 1'b1, 1'b0); cyc("gap_stall1", ESTALL);
                                                cyc("gap_stall2", ESTALL);
                                                cyc("gap_stall3", ESTALL);
                                                cyc("gap_issue", E0);
    drain();
    ins(5'd7, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);  cyc("lu_load", E0);
    ins(5'd8, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);  cyc("lu_stall1", ESTALL);
                                               cyc("lu_stall2", ESTALL);
                                               cyc("lu_stall3", ESTALL);
                                               cyc("lu_issue", E0);
    nop();                                     cyc("lu_fwd_tied", E0);
    drain();
`endif

    // x0 destinations never create hazards
    ins(5'd0,  5'd1, 5'd2, 1'b1, 1'b1, 1'b0); cyc("x0_prod", E0);
    ins(5'd13, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); cyc("x0_reader", E0);
    ins(5'd0,  5'd1, 5'd0, 1'b1, 1'b0, 1'b1); cyc("x0_fwd_none", E0);
    ins(5'd14, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); cyc("x0_load_nostall", E0);
    nop();                                    cyc("x0_load_fwd_none", E0);
    drain();

    // Redirect during a load-use stall, then a redirect that reloads FLUSH
    ins(5'd15, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1); cyc("rd_load", E0);
    ins(5'd16, 5'd15, 5'd0, 1'b1, 1'b0, 1'b0); cyc("rd_stall", ESTALL);
    ex_redirect = 1'b1;                        cyc("rd_redirect_beats_stall", EFLUSH);
    ex_redirect = 1'b0; nop();                 cyc("rd_flush_cycle", EFLUSH);
                                               cyc("rd_back_to_run", E0);
    ex_redirect = 1'b1;                        cyc("rl_redirect", EFLUSH);
                                               cyc("rl_redirect_in_flush", EFLUSH);
    ex_redirect = 1'b0;                        cyc("rl_reloaded", EFLUSH);
                                               cyc("rl_back_to_run", E0);
    drain();

    // Reset in the cycle after a load-use stall clears the scoreboard
    ins(5'd17, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1);  cyc("rs_load", E0);
    ins(5'd18, 5'd17, 5'd17, 1'b1, 1'b1, 1'b0); cyc("rs_stall", ESTALL);
    reset = 1'b1;                               cyc("rs_during_reset", E0);
    reset = 1'b0;
    ins(5'd19, 5'd18, 5'd17, 1'b1, 1'b1, 1'b0); cyc("rs_dep_after_reset", E0);
    nop();                                      cyc("rs_fwd_cleared", E0);
    drain();

    // Reset in a FLUSH cycle returns the FSM to RUN
    ex_redirect = 1'b1;                        cyc("rf_redirect", EFLUSH);
    reset = 1'b1;                              cyc("rf_reset_in_flush", E0);
    reset = 1'b0; ex_redirect = 1'b0;          cyc("rf_run_after_reset", E0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
